// File: rtl/dmem_pkg.sv
// Shared definitions for the handshaked data memory: access-size encodings,
// controller state encoding and the byte-lane mask helper.
package dmem_pkg;

  // Access size encodings carried on req_size
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Byte lanes touched by an access of the given size at the given byte offset
  // inside a word. Reserved sizes touch nothing.
  function automatic logic [3:0] laneMask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << off;
      SZ_HALF: m = 4'b0011 << off;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bundle between the MEM stage (master) and dmem_ctrl (slave).
interface dmem_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_fault;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane handling for dmem_ctrl: merges store data into the
// addressed byte lanes of a word, and extracts/extends load data.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] memWord,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        size,
  input  logic [1:0]        off,
  input  logic              isSigned,
  output logic [DATA_W-1:0] mergedWord,
  output logic [DATA_W-1:0] loadData
);
  localparam int NB = DATA_W / 8;

  logic [3:0]        maskS;
  logic [DATA_W-1:0] bitMaskS;
  logic [DATA_W-1:0] shWdataS;
  logic [DATA_W-1:0] shRdataS;
  logic [31:0]       extS;
  logic              unusedS;

  // Store path: shift right-justified data up to its lanes, keep other lanes
  always_comb begin
    maskS    = laneMask(size, off);
    bitMaskS = {DATA_W{1'b0}};
    for (int i = 0; i < NB; i++) begin
      bitMaskS[i*8 +: 8] = {8{maskS[i]}};
    end
    shWdataS   = wdata << {off, 3'b000};
    mergedWord = (memWord & ~bitMaskS) | (shWdataS & bitMaskS);
  end

  // Load path: right-justify the addressed lanes, then extend to 32 bits and
  // truncate, so both 16- and 32-bit words share one extension rule
  always_comb begin
    shRdataS = memWord >> {off, 3'b000};
    case (size)
      SZ_BYTE: extS = {{24{isSigned & shRdataS[7]}}, shRdataS[7:0]};
      SZ_HALF: extS = {{16{isSigned & shRdataS[15]}}, shRdataS[15:0]};
      default: extS = 32'(shRdataS);
    endcase
    loadData = extS[DATA_W-1:0];
  end

  // Mask and extension bits beyond a 16-bit word are dead in the narrow build
  assign unusedS = ^{maskS, extS};

endmodule

// File: rtl/dmem_ctrl.sv
// Handshaked byte/halfword/word data memory for the MEM stage.
// Optional feature macro: DMEM_RANGE_CHECK_EN -- when defined, addresses whose
// word index lies beyond DEPTH_WORDS fault; otherwise the index wraps.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  dmem_if.slave             bus,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  localparam int OFF_W     = (DATA_W == 32) ? 2 : 1;
  localparam int IDX_W     = $clog2(DEPTH_WORDS);
  localparam bit IS_NARROW = (DATA_W == 16);
  localparam bit NO_WAIT   = (WAIT_STATES == 0);

  logic [DATA_W-1:0] memR [DEPTH_WORDS];

  state_t            stateR;
  logic [2:0]        cntR;
  logic              reqReadyR;
  logic              respValidR;
  logic [DATA_W-1:0] respRdataR;
  logic              respFaultR;

  // Captured request, used once the FSM has left IDLE
  logic              weR;
  logic [1:0]        sizeR;
  logic              signedR;
  logic [IDX_W-1:0]  idxR;
  logic [1:0]        offR;
  logic [DATA_W-1:0] wdataR;
  logic              faultR;

  logic              acceptS;
  logic [1:0]        reqOffS;
  logic [IDX_W-1:0]  reqIdxS;
  logic              rangeFaultS;
  logic              reqFaultS;
  logic              enterRespS;
  logic              curWeS;
  logic [1:0]        curSizeS;
  logic              curSignedS;
  logic [IDX_W-1:0]  curIdxS;
  logic [1:0]        curOffS;
  logic [DATA_W-1:0] curWdataS;
  logic              curFaultS;
  logic [DATA_W-1:0] rdWordS;
  logic [DATA_W-1:0] mergedS;
  logic [DATA_W-1:0] loadS;
  logic              unusedS;

  assign acceptS = bus.req_valid && reqReadyR;

  // Decode the incoming request and classify faults at accept time
  always_comb begin
    reqOffS = 2'(bus.req_addr[OFF_W-1:0]);
    reqIdxS = bus.req_addr[OFF_W +: IDX_W];
`ifdef DMEM_RANGE_CHECK_EN
    rangeFaultS = |bus.req_addr[ADDR_W-1:OFF_W+IDX_W];
`else
    rangeFaultS = 1'b0;
`endif
    case (bus.req_size)
      SZ_BYTE: reqFaultS = rangeFaultS;
      SZ_HALF: reqFaultS = rangeFaultS | reqOffS[0];
      SZ_WORD: reqFaultS = rangeFaultS | IS_NARROW | (reqOffS != 2'b00);
      default: reqFaultS = 1'b1;
    endcase
  end

  // Select the live request: straight from the bus while IDLE (zero-wait and
  // fault paths reach RESP on the accepting edge), else the captured copy
  always_comb begin
    if (stateR == S_IDLE) begin
      curWeS     = bus.req_we;
      curSizeS   = bus.req_size;
      curSignedS = bus.req_signed;
      curIdxS    = reqIdxS;
      curOffS    = reqOffS;
      curWdataS  = bus.req_wdata;
      curFaultS  = reqFaultS;
    end else begin
      curWeS     = weR;
      curSizeS   = sizeR;
      curSignedS = signedR;
      curIdxS    = idxR;
      curOffS    = offR;
      curWdataS  = wdataR;
      curFaultS  = faultR;
    end
  end

  // Flag the edge that moves the FSM into RESP: commit and sample happen there
  always_comb begin
    if (stateR == S_IDLE) begin
      enterRespS = acceptS && (NO_WAIT || reqFaultS);
    end else if (stateR == S_WAIT) begin
      enterRespS = (cntR == 3'd0);
    end else begin
      enterRespS = 1'b0;
    end
  end

  assign rdWordS = memR[curIdxS];

  dmem_lane_align #(.DATA_W(DATA_W)) u_align (
    .memWord    (rdWordS),
    .wdata      (curWdataS),
    .size       (curSizeS),
    .off        (curOffS),
    .isSigned   (curSignedS),
    .mergedWord (mergedS),
    .loadData   (loadS)
  );

  // Storage: cleared on reset, written only by a non-faulting store entering RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        memR[i] <= {DATA_W{1'b0}};
      end
    end else if (enterRespS && curWeS && !curFaultS) begin
      memR[curIdxS] <= mergedS;
    end
  end

  // FSM, wait counter, request capture and registered response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      stateR     <= S_IDLE;
      cntR       <= 3'd0;
      reqReadyR  <= 1'b1;
      respValidR <= 1'b0;
      respRdataR <= {DATA_W{1'b0}};
      respFaultR <= 1'b0;
      weR        <= 1'b0;
      sizeR      <= SZ_BYTE;
      signedR    <= 1'b0;
      idxR       <= {IDX_W{1'b0}};
      offR       <= 2'b00;
      wdataR     <= {DATA_W{1'b0}};
      faultR     <= 1'b0;
    end else begin
      respValidR <= 1'b0;
      case (stateR)
        S_IDLE: begin
          if (acceptS) begin
            weR       <= bus.req_we;
            sizeR     <= bus.req_size;
            signedR   <= bus.req_signed;
            idxR      <= reqIdxS;
            offR      <= reqOffS;
            wdataR    <= bus.req_wdata;
            faultR    <= reqFaultS;
            reqReadyR <= 1'b0;
            if (NO_WAIT || reqFaultS) begin
              stateR <= S_RESP;
            end else begin
              stateR <= S_WAIT;
              cntR   <= 3'(WAIT_STATES - 1);
            end
          end
        end
        S_WAIT: begin
          if (cntR == 3'd0) begin
            stateR <= S_RESP;
          end else begin
            cntR <= cntR - 3'd1;
          end
        end
        S_RESP: begin
          stateR    <= S_IDLE;
          reqReadyR <= 1'b1;
        end
        default: begin
          stateR    <= S_IDLE;
          reqReadyR <= 1'b1;
        end
      endcase
      // Response data is zero for faults and for stores; loads return lanes
      if (enterRespS) begin
        respValidR <= 1'b1;
        respFaultR <= curFaultS;
        respRdataR <= (curFaultS || curWeS) ? {DATA_W{1'b0}} : loadS;
      end
    end
  end

  assign bus.req_ready  = reqReadyR;
  assign bus.resp_valid = respValidR;
  assign bus.resp_rdata = respRdataR;
  assign bus.resp_fault = respFaultR;

  assign dbg_data = memR[dbg_addr[OFF_W +: IDX_W]];

  // Address bits outside the word index are only consulted by the range check
  assign unusedS = ^{bus.req_addr[ADDR_W-1:OFF_W+IDX_W],
                     dbg_addr[ADDR_W-1:OFF_W+IDX_W], dbg_addr[OFF_W-1:0]};

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: instance A (WAIT_STATES=1) and instance B
// (WAIT_STATES=0) share stimulus; a byte-array model predicts every response.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  typedef struct packed {
    logic [15:0] rdata;
    logic        fault;
    logic [3:0]  lat;
  } expT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        useB = 1'b0;
  logic        tbValid = 1'b0;
  logic        tbWe = 1'b0;
  logic [1:0]  tbSize = 2'b00;
  logic        tbSigned = 1'b0;
  logic [15:0] tbAddr = 16'h0000;
  logic [15:0] tbWdata = 16'h0000;
  logic [15:0] dbgAddr = 16'h0000;
  logic [15:0] dbgDataA;
  logic [15:0] dbgDataB;

  logic [7:0]  refMem [2][128];
  expT         expQ[$];
  int          checkCnt = 0;
  int          failCnt = 0;

  dmem_if #(.DATA_W(16), .ADDR_W(16)) ifA ();
  dmem_if #(.DATA_W(16), .ADDR_W(16)) ifB ();

  assign ifA.req_valid  = tbValid & ~useB;
  assign ifB.req_valid  = tbValid & useB;
  assign ifA.req_we     = tbWe;
  assign ifB.req_we     = tbWe;
  assign ifA.req_size   = tbSize;
  assign ifB.req_size   = tbSize;
  assign ifA.req_signed = tbSigned;
  assign ifB.req_signed = tbSigned;
  assign ifA.req_addr   = tbAddr;
  assign ifB.req_addr   = tbAddr;
  assign ifA.req_wdata  = tbWdata;
  assign ifB.req_wdata  = tbWdata;

  wire        respValid = useB ? ifB.resp_valid : ifA.resp_valid;
  wire        reqReady  = useB ? ifB.req_ready  : ifA.req_ready;
  wire [15:0] respRdata = useB ? ifB.resp_rdata : ifA.resp_rdata;
  wire        respFault = useB ? ifB.resp_fault : ifA.resp_fault;

  dmem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH_WORDS(64), .WAIT_STATES(1)) dutA (
    .clk(clk), .rst(rst), .bus(ifA.slave), .dbg_addr(dbgAddr), .dbg_data(dbgDataA)
  );
  dmem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH_WORDS(64), .WAIT_STATES(0)) dutB (
    .clk(clk), .rst(rst), .bus(ifB.slave), .dbg_addr(dbgAddr), .dbg_data(dbgDataB)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    if (obs !== exp) begin
      failCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clearModel();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 128; i++) refMem[d][i] = 8'h00;
  endtask

  // Issue one request, predict its response, then check the response window
  task automatic doReq(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [15:0] addr, input logic [15:0] wd);
    expT        e;
    int         d;
    int         n;
    int         gotLat;
    logic       flt;
    logic [6:0] ea;
    logic [15:0] gotData;
    logic       gotFault;
    d = useB ? 1 : 0;
    n = 0;
    while (reqReady !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkVal("ready_wait", 32'(reqReady), 32'd1);
    flt = (sz == 2'b11) || (sz == 2'b10) || (sz == 2'b01 && addr[0]);
`ifdef DMEM_RANGE_CHECK_EN
    if (addr >= 16'd128) flt = 1'b1;
`endif
    ea = addr[6:0];
    e.fault = flt;
    e.rdata = 16'h0000;
    e.lat   = flt ? 4'd1 : (useB ? 4'd1 : 4'd2);
    if (!flt) begin
      if (we) begin
        refMem[d][ea] = wd[7:0];
        if (sz == 2'b01) refMem[d][ea + 7'd1] = wd[15:8];
      end else if (sz == 2'b00) begin
        e.rdata = sg ? {{8{refMem[d][ea][7]}}, refMem[d][ea]} : {8'h00, refMem[d][ea]};
      end else begin
        e.rdata = {refMem[d][ea + 7'd1], refMem[d][ea]};
      end
    end
    expQ.push_back(e);
    tbWe = we; tbSize = sz; tbSigned = sg; tbAddr = addr; tbWdata = wd; tbValid = 1'b1;
    @(posedge clk);
    #1 tbValid = 1'b0;
    gotLat = 0; gotData = 16'h0000; gotFault = 1'b0;
    for (int c = 1; c <= 12 && gotLat == 0; c++) begin
      @(negedge clk);
      checkVal("busy", 32'(reqReady), 32'd0);
      if (respValid === 1'b1) begin
        gotLat = c; gotData = respRdata; gotFault = respFault;
      end
    end
    e = expQ.pop_front();
    checkVal("latency", 32'(gotLat), 32'(e.lat));
    checkVal("rdata", 32'(gotData), 32'(e.rdata));
    checkVal("fault", 32'(gotFault), 32'(e.fault));
    @(negedge clk);
    checkVal("strobe_one", 32'(respValid), 32'd0);
    checkVal("ready_back", 32'(reqReady), 32'd1);
    checkVal("hold_rdata", 32'(respRdata), 32'(e.rdata));
    checkVal("hold_fault", 32'(respFault), 32'(e.fault));
  endtask

  task automatic checkDbgA(input logic [15:0] addr);
    logic [6:0] a;
    a = {addr[6:1], 1'b0};
    dbgAddr = addr;
    #1 checkVal("dbg_data", 32'(dbgDataA), 32'({refMem[0][a + 7'd1], refMem[0][a]}));
  endtask

  task automatic checkIdleA(input string tag);
    checkVal({tag, "_ready"}, 32'(ifA.req_ready), 32'd1);
    checkVal({tag, "_valid"}, 32'(ifA.resp_valid), 32'd0);
    checkVal({tag, "_rdata"}, 32'(ifA.resp_rdata), 32'd0);
    checkVal({tag, "_fault"}, 32'(ifA.resp_fault), 32'd0);
  endtask

  initial begin
    clearModel();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkIdleA("reset");
    checkVal("reset_readyB", 32'(ifB.req_ready), 32'd1);

    // Loads from freshly cleared memory
    for (int i = 0; i < 5; i++) doReq(1'b0, SZ_HALF, 1'b0, 16'(2 * i), 16'h0000);

    // Full-word store, read back and debug view
    doReq(1'b1, SZ_HALF, 1'b0, 16'h0000, 16'h0FFF);
    checkDbgA(16'h0000);
    doReq(1'b0, SZ_HALF, 1'b0, 16'h0000, 16'h0000);

    // Sub-word store merge and extension
    doReq(1'b1, SZ_HALF, 1'b0, 16'h0002, 16'h1234);
    doReq(1'b1, SZ_BYTE, 1'b0, 16'h0003, 16'h00AA);
    checkDbgA(16'h0002);
    doReq(1'b0, SZ_HALF, 1'b0, 16'h0002, 16'h0000);
    doReq(1'b0, SZ_BYTE, 1'b1, 16'h0003, 16'h0000);
    doReq(1'b0, SZ_BYTE, 1'b0, 16'h0003, 16'h0000);

    // Faulting stores leave memory alone
    doReq(1'b1, SZ_HALF, 1'b0, 16'h0005, 16'hDEAD);
    doReq(1'b1, SZ_WORD, 1'b0, 16'h0004, 16'hCAFE);
    doReq(1'b1, SZ_RSVD, 1'b0, 16'h0004, 16'hCAFE);
    doReq(1'b0, SZ_HALF, 1'b0, 16'h0002, 16'h0000);
    doReq(1'b0, SZ_HALF, 1'b0, 16'h0004, 16'h0000);
    checkDbgA(16'h0004);

    // Low-byte lane, positive signed byte, signed halfword
    doReq(1'b1, SZ_BYTE, 1'b0, 16'h0004, 16'h0080);
    doReq(1'b1, SZ_BYTE, 1'b0, 16'h0005, 16'h007F);
    doReq(1'b0, SZ_BYTE, 1'b1, 16'h0004, 16'h0000);
    doReq(1'b0, SZ_BYTE, 1'b1, 16'h0005, 16'h0000);
    doReq(1'b0, SZ_HALF, 1'b1, 16'h0004, 16'h0000);

    // Reset while a store waits: no response, back to IDLE
    tbWe = 1'b1; tbSize = SZ_HALF; tbSigned = 1'b0; tbAddr = 16'h0006; tbWdata = 16'hBEEF;
    tbValid = 1'b1;
    @(posedge clk);
    #1 tbValid = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    clearModel();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkIdleA("rst_wait");
    end
    doReq(1'b0, SZ_HALF, 1'b0, 16'h0006, 16'h0000);

    // Reset wins over a same-cycle accept
    doReq(1'b1, SZ_HALF, 1'b0, 16'h0008, 16'h4321);
    tbWe = 1'b1; tbSize = SZ_HALF; tbAddr = 16'h000A; tbWdata = 16'h1111;
    tbValid = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1 tbValid = 1'b0; rst = 1'b0;
    clearModel();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkIdleA("rst_accept");
    end
    doReq(1'b0, SZ_HALF, 1'b0, 16'h000A, 16'h0000);
    doReq(1'b0, SZ_HALF, 1'b0, 16'h0008, 16'h0000);

    // Zero-wait instance
    useB = 1'b1;
    doReq(1'b1, SZ_HALF, 1'b0, 16'h0006, 16'hBEEF);
    doReq(1'b0, SZ_HALF, 1'b0, 16'h0006, 16'h0000);
    doReq(1'b0, SZ_BYTE, 1'b1, 16'h0007, 16'h0000);
    doReq(1'b0, SZ_HALF, 1'b0, 16'h0003, 16'h0000);
    useB = 1'b0;

    // Out-of-range address: fault or wrap depending on build
    doReq(1'b1, SZ_HALF, 1'b0, 16'h0000, 16'h5A5A);
    doReq(1'b0, SZ_HALF, 1'b0, 16'h0080, 16'h0000);
    doReq(1'b0, SZ_BYTE, 1'b0, 16'h0081, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checkCnt, failCnt);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
